// File: rtl/fifo_uart_drain_if.sv
// FIFO read-port bundle between the byte FIFO and its UART drain.
// The drain is the master: it owns fifo_read_en. The FIFO side is the slave.
interface fifo_uart_drain_if;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       fifo_read_en;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_read_en
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_read_en
  );
endinterface

// File: rtl/fifo_uart_drain.sv
// fifo_uart_drain: pops bytes from the FIFO one at a time and sends each as a
// UART frame on tx.
// Frame layout: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Every output comes straight from a flop, so tx never glitches on the pin.
module fifo_uart_drain #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  fifo_uart_drain_if.master        fifo,
  output logic                     tx,
  output logic                     busy,
  output logic [15:0]              bytes_sent
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SENT_W = 16;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(7);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]    bit_idx;
  logic [BYTE_W-1:0]   shift;
  logic                parity_bit;
  logic [SENT_W-1:0]   sent_count;
  logic                baud_done_c;

  // The last clk of the current bit period.
  assign baud_done_c = (baud_cnt == BAUD_LAST);
  assign bytes_sent  = sent_count;

  // Frame sequencer. Outputs are set for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      tx                <= 1'b1;
      busy              <= 1'b0;
      fifo.fifo_read_en <= 1'b0;
      sent_count        <= '0;
      baud_cnt          <= '0;
      bit_idx           <= '0;
      shift             <= '0;
      parity_bit        <= 1'b0;
    end else begin
      fifo.fifo_read_en <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (enable && !fifo.fifo_empty) begin
            state             <= FETCH;
            fifo.fifo_read_en <= 1'b1;
            busy              <= 1'b1;
          end
        end

        // The pop is in flight. The FIFO presents the byte during CAPTURE.
        FETCH: begin
          state <= CAPTURE;
        end

        CAPTURE: begin
          shift      <= fifo.fifo_rd_data;
          parity_bit <= PARITY_EN ? ^fifo.fifo_rd_data : 1'b0;
          bit_idx    <= '0;
          baud_cnt   <= '0;
          state      <= START;
          tx         <= 1'b0;
        end

        START: begin
          if (baud_done_c) begin
            baud_cnt <= '0;
            state    <= DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (baud_done_c) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              if (PARITY_EN) begin
                state <= PARITY;
                tx    <= parity_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              shift   <= {1'b0, shift[BYTE_W-1:1]};
              tx      <= shift[1];
              bit_idx <= bit_idx + BIT_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        PARITY: begin
          if (baud_done_c) begin
            baud_cnt <= '0;
            state    <= STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (baud_done_c) begin
            baud_cnt   <= '0;
            sent_count <= sent_count + SENT_W'(1);
            state      <= IDLE;
            busy       <= 1'b0;
            tx         <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Bench for fifo_uart_drain. u0 has no parity and u1 has even parity, and both use C=4.
// Each instance has a behavioural FIFO. Bytes are pushed into the FIFO and into an
// expected-frame queue together. A line monitor pops the expected byte at each start
// bit and checks every tx cycle of the frame.
`timescale 1ns/1ps
module tb_fifo_uart_drain;

  localparam int unsigned C  = 4;
  localparam int unsigned F0 = 10 * C;
  localparam int unsigned F1 = 11 * C;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        en0   = 1'b0;
  logic        en1   = 1'b0;
  logic        tx0, tx1, busy0, busy1;
  logic [15:0] bs0, bs1;

  int unsigned cyc    = 0;
  int unsigned n_run  = 0;
  int unsigned n_fail = 0;
  int unsigned pops0  = 0;
  int unsigned pops1  = 0;
  int unsigned done0  = 0;
  int unsigned done1  = 0;
  logic [7:0]  last_rx0 = 8'h00;

  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [7:0]  exp0[$];
  logic [7:0]  exp1[$];
  int unsigned starts0[$];

  fifo_uart_drain_if f0 ();
  fifo_uart_drain_if f1 ();

  fifo_uart_drain #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0)) u0 (
    .clk        (clk),
    .reset      (reset),
    .enable     (en0),
    .fifo       (f0),
    .tx         (tx0),
    .busy       (busy0),
    .bytes_sent (bs0)
  );

  fifo_uart_drain #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1)) u1 (
    .clk        (clk),
    .reset      (reset),
    .enable     (en1),
    .fifo       (f1),
    .tx         (tx1),
    .busy       (busy1),
    .bytes_sent (bs1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // FIFO models: registered data_out and registered empty flag.
  always @(posedge clk) begin
    if (f0.fifo_read_en === 1'b1) begin
      pops0++;
      check("pop_nonempty0", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) f0.fifo_rd_data <= q0.pop_front();
    end
    f0.fifo_empty <= (q0.size() == 0);
  end

  always @(posedge clk) begin
    if (f1.fifo_read_en === 1'b1) begin
      pops1++;
      check("pop_nonempty1", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) f1.fifo_rd_data <= q1.pop_front();
    end
    f1.fifo_empty <= (q1.size() == 0);
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Line monitor. A frame cut short by reset is dropped.
  task automatic monitor(input int idx);
    logic [10:0] frame;
    logic [7:0]  b;
    logic [7:0]  rx;
    logic        tx_s;
    bit          aborted;
    int unsigned nbits;
    nbits = (idx == 1) ? 11 : 10;
    forever begin
      @(posedge clk);
      #1;
      tx_s = (idx == 0) ? tx0 : tx1;
      if (reset == 1'b0 && tx_s === 1'b0) begin
        b = 8'h00;
        if (idx == 0) begin
          check("frame_expected0", 32'(exp0.size() != 0), 32'd1);
          if (exp0.size() != 0) b = exp0.pop_front();
          starts0.push_back(cyc);
        end else begin
          check("frame_expected1", 32'(exp1.size() != 0), 32'd1);
          if (exp1.size() != 0) b = exp1.pop_front();
        end
        if (idx == 1) frame = {1'b1, ^b, b, 1'b0};
        else          frame = {1'b0, 1'b1, b, 1'b0};
        rx = 8'h00;
        aborted = 1'b0;
        for (int s = 0; s < int'(nbits); s++) begin
          for (int k = 0; k < int'(C); k++) begin
            if (s != 0 || k != 0) begin
              @(posedge clk);
              #1;
            end
            if (reset) aborted = 1'b1;
            if (aborted) break;
            tx_s = (idx == 0) ? tx0 : tx1;
            if (s >= 1 && s <= 8 && k == int'(C / 2)) rx[s-1] = tx_s;
            check($sformatf("tx%0d_byte%02h_slot%0d", idx, b, s), 32'(tx_s), 32'(frame[s]));
          end
          if (aborted) break;
        end
        if (!aborted) begin
          if (idx == 0) begin
            done0++;
            last_rx0 = rx;
          end else begin
            done1++;
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic wait_pop(input int idx, input int unsigned max_cyc, output int unsigned p);
    bit seen;
    seen = 1'b0;
    p = 0;
    for (int unsigned i = 0; i < max_cyc && !seen; i++) begin
      tick(1);
      if (((idx == 0) ? f0.fifo_read_en : f1.fifo_read_en) === 1'b1) begin
        seen = 1'b1;
        p = cyc;
      end
    end
    check($sformatf("pop_seen%0d", idx), 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input int idx, input int unsigned max_cyc, output int unsigned t);
    bit seen;
    seen = 1'b0;
    t = 0;
    for (int unsigned i = 0; i < max_cyc && !seen; i++) begin
      tick(1);
      if (((idx == 0) ? busy0 : busy1) === 1'b0) begin
        seen = 1'b1;
        t = cyc;
      end
    end
    check($sformatf("busy_drop%0d", idx), 32'(seen), 32'd1);
  endtask

  task automatic wait_frames0(input int unsigned target, input int unsigned max_cyc);
    int unsigned i;
    i = 0;
    while (done0 < target && i < max_cyc) begin
      tick(1);
      i++;
    end
    check("frames_done0", 32'(done0), 32'(target));
  endtask

  // Parity frame on u1. Checks the parity slot value and the frame length.
  task automatic send_parity(input logic [7:0] b, input logic pbit);
    int unsigned p;
    int unsigned t;
    @(negedge clk);
    q1.push_back(b);
    exp1.push_back(b);
    wait_pop(1, 10, p);
    tick(2 + 9 * C + 1);
    check($sformatf("parity_bit_%02h", b), 32'(tx1), 32'(pbit));
    wait_idle(1, 30, t);
    check($sformatf("frame_len_%02h", b), 32'(t - p - 2), 32'(F1));
  endtask

  initial begin
    int unsigned p;
    int unsigned t;
    int unsigned base;

    // Reset state, with both FIFOs empty.
    reset = 1'b1;
    tick(3);
    check("rst_tx0",   32'(tx0), 32'd1);
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_rd0",   32'(f0.fifo_read_en), 32'd0);
    check("rst_cnt0",  32'(bs0), 32'd0);
    check("rst_tx1",   32'(tx1), 32'd1);
    check("rst_cnt1",  32'(bs1), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    en0 = 1'b1;
    en1 = 1'b1;
    tick(100);
    check("idle_no_pop0", 32'(pops0), 32'd0);
    check("idle_no_pop1", 32'(pops1), 32'd0);
    check("idle_tx0", 32'(tx0), 32'd1);

    // Single byte 0xA5 without parity.
    @(negedge clk);
    q0.push_back(8'hA5);
    exp0.push_back(8'hA5);
    wait_pop(0, 10, p);
    tick(1);
    check("pulse_width", 32'(f0.fifo_read_en), 32'd0);
    tick(40);
    check("busy_last_cycle", 32'(busy0), 32'd1);
    check("cnt_before_stop_end", 32'(bs0), 32'd0);
    tick(1);
    check("busy_after_frame", 32'(busy0), 32'd0);
    check("cnt_after_frame", 32'(bs0), 32'd1);
    tick(20);
    check("single_pops", 32'(pops0), 32'd1);
    check("single_rx", 32'(last_rx0), 32'h0A5);

    // Even parity on u1.
    send_parity(8'h07, 1'b1);
    send_parity(8'h03, 1'b0);
    tick(10);
    check("parity_frames", 32'(done1), 32'd2);
    check("parity_cnt", 32'(bs1), 32'd2);

    // Drain 16 bytes back-to-back.
    @(negedge clk);
    reset = 1'b1;
    en0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      q0.push_back(8'(i));
      exp0.push_back(8'(i));
    end
    starts0.delete();
    base = done0;
    @(negedge clk);
    en0 = 1'b1;
    wait_frames0(base + 16, 16 * (F0 + 3) + 50);
    tick(2);
    check("drain_cnt", 32'(bs0), 32'd16);
    check("drain_starts", 32'(starts0.size()), 32'd16);
    for (int i = 1; i < 16 && i < starts0.size(); i++)
      check($sformatf("drain_gap%0d", i), 32'(starts0[i] - starts0[i-1] - F0), 32'd3);
    tick(30);
    check("drain_pops", 32'(pops0), 32'd17);
    check("drain_idle", 32'(busy0), 32'd0);

    // Enable drops during DATA: the frame finishes and no further pop happens.
    @(negedge clk);
    q0.push_back(8'h3C);
    q0.push_back(8'h5A);
    exp0.push_back(8'h3C);
    base = done0;
    wait_pop(0, 10, p);
    tick(2 + C + 2);
    @(negedge clk);
    en0 = 1'b0;
    wait_idle(0, 60, t);
    tick(30);
    check("endrop_pops", 32'(pops0), 32'd18);
    check("endrop_frames", 32'(done0), 32'(base + 1));
    check("endrop_cnt", 32'(bs0), 32'd17);
    check("endrop_rx", 32'(last_rx0), 32'h03C);

    // Reset during bit 3. 0x5A is lost and the next frame carries 0x96.
    @(negedge clk);
    q0.push_back(8'h96);
    exp0.push_back(8'h5A);
    exp0.push_back(8'h96);
    en0 = 1'b1;
    base = done0;
    wait_pop(0, 10, p);
    tick(2 + 4 * C + 1);
    @(negedge clk);
    reset = 1'b1;
    tick(1);
    check("midrst_tx", 32'(tx0), 32'd1);
    check("midrst_cnt", 32'(bs0), 32'd0);
    check("midrst_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_frames0(base + 1, F0 + 40);
    tick(2);
    check("after_rst_cnt", 32'(bs0), 32'd1);
    check("after_rst_rx", 32'(last_rx0), 32'h096);
    check("after_rst_pops", 32'(pops0), 32'd20);

    // bytes_sent wraps from 0xFFFF to 0x0000.
    @(negedge clk);
    force u0.sent_count = 16'hFFFF;
    @(negedge clk);
    release u0.sent_count;
    tick(1);
    check("preload", 32'(bs0), 32'h0FFFF);
    @(negedge clk);
    q0.push_back(8'h81);
    exp0.push_back(8'h81);
    base = done0;
    wait_frames0(base + 1, F0 + 40);
    tick(2);
    check("wrap_cnt", 32'(bs0), 32'd0);
    check("wrap_rx", 32'(last_rx0), 32'h081);

    tick(5);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before cycle 50000");
    $fatal(1, "watchdog expired");
  end

endmodule
